// File: rtl/upload_pkg.sv
// Shared types and constants for the HPS upload (save-RAM read-back) path.
package upload_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACQUIRE,
        READY,
        FETCH,
        LATCH
    } upl_state_t;

    localparam logic [7:0] UPL_OOR_BYTE  = 8'hFF;
    localparam logic [7:0] UPL_IDX_NVRAM = 8'd4;

endpackage

// File: rtl/nvram_upload_reader.sv
// Serves hps_io ioctl_rd byte requests from save RAM, arbitrating for the RAM
// port with a req/grant handshake so the CPU is paused rather than corrupted.
module nvram_upload_reader
    import upload_pkg::*;
#(
    parameter int         ADDR_W = 11,
    parameter logic [7:0] INDEX  = UPL_IDX_NVRAM
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              save_req,
    output logic              ioctl_upload_req,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_dout,
    output logic              busy,
    output logic              done
);

    upl_state_t        state_q, state_d;
    logic              pending_q, pending_d;
    logic              oor_q, oor_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              done_q, done_d;
    logic              req_q, req_d;
    logic              defer_q, defer_d;

    logic sel, rd, rd_oor, pend_eff, oor_eff, serve, end_up;

    assign sel      = ioctl_upload && (ioctl_index == INDEX);
    // Reads aimed at another transfer index are not ours to serve.
    assign rd       = ioctl_rd && sel;
    assign rd_oor   = (ioctl_addr >> ADDR_W) != 25'd0;
    assign pend_eff = pending_q || rd;
    assign oor_eff  = rd ? rd_oor : oor_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pend_eff;
        addr_d    = rd ? ioctl_addr[ADDR_W-1:0] : addr_q;
        oor_d     = oor_eff;
        din_d     = din_q;
        done_d    = 1'b0;
        serve     = 1'b0;
        end_up    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sel) state_d = ACQUIRE;
            end
            ACQUIRE: begin
                if (!sel) begin
                    end_up = 1'b1;
                end else if (bus_gnt) begin
                    state_d = READY;
                    serve   = pend_eff;
                end
            end
            READY: begin
                if (!sel)          end_up  = 1'b1;
                else if (!bus_gnt) state_d = ACQUIRE;
                else               serve   = pend_eff;
            end
            FETCH: begin
                // Grantor honours a held ram_rd cycle, so grant loss waits for LATCH.
                state_d = LATCH;
            end
            LATCH: begin
                din_d = ram_dout;
                if (sel) state_d = READY;
                else     end_up  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (serve) begin
            pending_d = 1'b0;
            if (oor_eff) din_d   = UPL_OOR_BYTE;
            else         state_d = FETCH;
        end

        if (end_up) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            done_d    = 1'b1;
        end
    end

    // A save request seen while busy is replayed when the current upload ends.
    always_comb begin
        req_d   = req_q;
        defer_d = defer_q;
        if (save_req && state_q != IDLE) defer_d = 1'b1;
        if (sel)                                   req_d = 1'b0;
        else if (save_req && state_q == IDLE)      req_d = 1'b1;
        if (end_up) begin
            req_d   = defer_q || save_req;
            defer_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            oor_q     <= 1'b0;
            addr_q    <= '0;
            din_q     <= 8'h00;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            defer_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            oor_q     <= oor_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            done_q    <= done_d;
            req_q     <= req_d;
            defer_q   <= defer_d;
        end
    end

    assign ioctl_upload_req = req_q;
    assign ioctl_din        = din_q;
    assign ram_addr         = addr_q;
    assign ram_rd           = (state_q == FETCH);
    assign busy             = (state_q != IDLE);
    assign bus_req          = (state_q != IDLE);
    assign done             = done_q;

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Directed bench for nvram_upload_reader: table of reads plus hand-written
// sequences for grant loss, upload end, index mismatch and async reset.
module tb_nvram_upload_reader;

    localparam int ADDR_W = 11;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              save_req;
    logic              ioctl_upload_req;
    logic              ioctl_upload;
    logic [7:0]        ioctl_index;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              bus_req;
    logic              bus_gnt;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [7:0]        ram_dout = 8'h00;
    logic              busy;
    logic              done;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int snap;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  exp_din;
        int          exp_rd;
    } vec_t;
    vec_t vecs [8];

    always #5 clk_sys = ~clk_sys;

    nvram_upload_reader #(.ADDR_W(ADDR_W), .INDEX(8'd4)) dut (
        .clk_sys          (clk_sys),
        .reset_n          (reset_n),
        .save_req         (save_req),
        .ioctl_upload_req (ioctl_upload_req),
        .ioctl_upload     (ioctl_upload),
        .ioctl_index      (ioctl_index),
        .ioctl_rd         (ioctl_rd),
        .ioctl_addr       (ioctl_addr),
        .ioctl_din        (ioctl_din),
        .bus_req          (bus_req),
        .bus_gnt          (bus_gnt),
        .ram_addr         (ram_addr),
        .ram_rd           (ram_rd),
        .ram_dout         (ram_dout),
        .busy             (busy),
        .done             (done)
    );

    // Save RAM model: one-cycle read latency.
    always @(posedge clk_sys) begin
        if (ram_rd) begin
            ram_dout <= mem[ram_addr];
            rd_cnt   <= rd_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic issue_rd(input logic [24:0] a);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick(1);
        ioctl_rd   = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b1;
        save_req     = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        bus_gnt      = 1'b1;
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 8'h00;
        mem[0] = 8'h3C; mem[1] = 8'h11; mem[5] = 8'hA5; mem[6] = 8'h66;
        mem[100] = 8'h42; mem[1024] = 8'hC3; mem[2047] = 8'h77;

        vecs[0] = '{25'd2047,      8'h77, 1};
        vecs[1] = '{25'd2048,      8'hFF, 0};
        vecs[2] = '{25'd0,         8'h3C, 1};
        vecs[3] = '{25'd1024,      8'hC3, 1};
        vecs[4] = '{25'h1FFFFFF,   8'hFF, 0};
        vecs[5] = '{25'd6,         8'h66, 1};
        vecs[6] = '{25'd2053,      8'hFF, 0};
        vecs[7] = '{25'd1,         8'h11, 1};

        #2 reset_n = 1'b0;
        tick(2);
        check("rst_req",     ioctl_upload_req, 0);
        check("rst_din",     ioctl_din, 8'h00);
        check("rst_bus_req", bus_req, 0);
        check("rst_ram_rd",  ram_rd, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        reset_n = 1'b1;
        tick(1);

        // Request latch set, then cleared when the upload is selected
        save_req = 1'b1; tick(1); save_req = 1'b0;
        check("req_set", ioctl_upload_req, 1);
        check("req_idle_busy", busy, 0);
        ioctl_upload = 1'b1; ioctl_index = 8'd4;
        tick(1);
        check("req_clear", ioctl_upload_req, 0);
        check("acq_bus_req", bus_req, 1);
        tick(1);

        // Basic read with exact latency
        snap = rd_cnt;
        issue_rd(25'd5);
        check("basic_ram_rd", ram_rd, 1);
        check("basic_ram_addr", ram_addr, 5);
        tick(1);
        check("basic_din_early", ioctl_din, 8'h00);
        tick(1);
        check("basic_din", ioctl_din, 8'hA5);
        check("basic_rd_cnt", rd_cnt - snap, 1);

        for (int v = 0; v < 8; v++) begin
            tick(6);
            snap = rd_cnt;
            issue_rd(vecs[v].addr);
            tick(2);
            check($sformatf("vec%0d_din", v), ioctl_din, vecs[v].exp_din);
            tick(3);
            check($sformatf("vec%0d_rd_cnt", v), rd_cnt - snap, vecs[v].exp_rd);
        end

        // Grant loss in READY with a read pending; save_req while busy is deferred
        tick(4);
        save_req = 1'b1; bus_gnt = 1'b0;
        tick(1);
        save_req = 1'b0;
        check("defer_req_low", ioctl_upload_req, 0);
        snap = rd_cnt;
        issue_rd(25'd100);
        tick(3);
        check("gloss_bus_req", bus_req, 1);
        check("gloss_busy", busy, 1);
        check("gloss_no_rd", rd_cnt - snap, 0);
        check("gloss_din_hold", ioctl_din, 8'h11);
        bus_gnt = 1'b1;
        tick(3);
        check("gloss_din", ioctl_din, 8'h42);
        check("gloss_rd_cnt", rd_cnt - snap, 1);

        // ioctl_rd landing in the LATCH cycle is served next
        tick(6);
        issue_rd(25'd1);
        tick(1);
        ioctl_addr = 25'd6; ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        check("latch_rd_first", ioctl_din, 8'h11);
        tick(3);
        check("latch_rd_second", ioctl_din, 8'h66);

        // End of upload: done pulse, bus released, deferred request replayed
        tick(4);
        ioctl_upload = 1'b0;
        tick(1);
        check("end_done", done, 1);
        check("end_bus_req", bus_req, 0);
        check("end_busy", busy, 0);
        check("end_req_replay", ioctl_upload_req, 1);
        tick(1);
        check("end_done_pulse", done, 0);

        // Index mismatch: nothing happens
        ioctl_upload = 1'b1; ioctl_index = 8'd0;
        tick(2);
        snap = rd_cnt;
        issue_rd(25'd1);
        tick(5);
        check("mis_bus_req", bus_req, 0);
        check("mis_din", ioctl_din, 8'h66);
        check("mis_no_rd", rd_cnt - snap, 0);
        check("mis_req_kept", ioctl_upload_req, 1);
        ioctl_upload = 1'b0;
        tick(1);

        // Delayed grant: first byte arrives three cycles after grant
        bus_gnt = 1'b0; ioctl_index = 8'd4; ioctl_upload = 1'b1;
        tick(1);
        check("dg_req_clear", ioctl_upload_req, 0);
        snap = rd_cnt;
        issue_rd(25'd0);
        tick(18);
        check("dg_no_rd", rd_cnt - snap, 0);
        check("dg_bus_req", bus_req, 1);
        bus_gnt = 1'b1;
        tick(2);
        check("dg_din_early", ioctl_din, 8'h66);
        tick(1);
        check("dg_din", ioctl_din, 8'h3C);
        ioctl_upload = 1'b0;
        tick(1);
        check("dg_done", done, 1);
        check("dg_req_none", ioctl_upload_req, 0);
        tick(1);

        // save_req coincident with sel rising leaves the latch cleared
        save_req = 1'b1; ioctl_upload = 1'b1;
        tick(1);
        save_req = 1'b0;
        check("same_cycle_req", ioctl_upload_req, 0);
        tick(1);

        // Asynchronous reset during FETCH
        issue_rd(25'd5);
        check("fetch_ram_rd", ram_rd, 1);
        reset_n = 1'b0;
        #1;
        check("arst_ram_rd", ram_rd, 0);
        check("arst_bus_req", bus_req, 0);
        check("arst_busy", busy, 0);
        check("arst_din", ioctl_din, 8'h00);
        check("arst_ram_addr", ram_addr, 0);
        check("arst_req", ioctl_upload_req, 0);
        check("arst_done", done, 0);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nvram_upload_reader.md
# nvram_upload_reader

Responder for the HPS-side upload path: it serves `ioctl_rd` byte requests from the core's save RAM (high scores, settings) so the framework can write them to the SD card. It sits between `hps_io` and the `system` block's save-RAM port. It is the read-back counterpart of the `ioctl` download writer. It arbitrates for the RAM with a req/grant handshake so the CPU is never corrupted mid-access.

## Interface
Parameters:
- `ADDR_W`, 11: save RAM address width; capacity 2^ADDR_W bytes.
- `INDEX`, 8'd4: `ioctl_index` value this block answers.

Ports:
- `clk_sys`, input, 1: system clock; all logic on rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `save_req`, input, 1: one-cycle pulse from core requesting an upload.
- `ioctl_upload_req`, output, 1: upload request to `hps_io`.
- `ioctl_upload`, input, 1: upload in progress (`hps_io`).
- `ioctl_index`, input, 8: current transfer index.
- `ioctl_rd`, input, 1: one-cycle byte-read strobe.
- `ioctl_addr`, input, 25: byte address of the requested byte.
- `ioctl_din`, output, 8: byte returned to `hps_io`.
- `bus_req`, output, 1: request exclusive RAM access.
- `bus_gnt`, input, 1: RAM access granted (level).
- `ram_addr`, output, ADDR_W: RAM address.
- `ram_rd`, output, 1: RAM read enable. Read data is valid 1 cycle later.
- `ram_dout`, input, 8: RAM read data.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse when an upload ends.

## Operation
- Match condition: `sel = ioctl_upload && ioctl_index == INDEX`.
- Request latch: `save_req` sets `ioctl_upload_req`. It clears on the first cycle `sel` is high. A `save_req` arriving while `busy` re-sets the latch after `done`; the request is never lost.
- FSM states:
  - IDLE: `bus_req`=0. Moves to ACQUIRE when `sel` rises.
  - ACQUIRE: `bus_req`=1. Moves to READY when `bus_gnt`=1.
  - READY: holds the bus and waits for a pending read.
  - FETCH: `ram_rd`=1, `ram_addr`=latched address. Moves to LATCH.
  - LATCH: `ioctl_din` <= `ram_dout`. Moves to READY.
- Pending read: an `ioctl_rd` pulse latches `ioctl_addr[ADDR_W-1:0]` and sets a `pending` flag in any state. READY with `pending` moves to FETCH and clears `pending`.
- Out of range: if `ioctl_addr >= 2^ADDR_W`, no RAM access occurs. `ioctl_din` <= 8'hFF directly from READY; the FSM stays in READY.
- Grant loss: `bus_gnt` dropping in READY returns to ACQUIRE, with `bus_req` still high and `pending` preserved. In FETCH, a drop is ignored until LATCH completes, because the grantor must honour a held `ram_rd` cycle.
- End of upload: `sel` falling in any non-IDLE state moves to IDLE after any in-flight LATCH. On that transition:
  - `bus_req` drops.
  - `pending` clears.
  - `done` pulses.
- `ioctl_din` holds its last value between reads.

## Timing
- Reset values: `ioctl_upload_req`=0, `ioctl_din`=8'h00, `bus_req`=0, `ram_rd`=0, `ram_addr`=0, `busy`=0, `done`=0. FSM=IDLE, `pending`=0.
- Reset asserted mid-upload: all outputs return to reset values immediately (asynchronous); `bus_req` released.
- Read latency with bus held, from `ioctl_rd` at cycle T:
  - `pending` at T+1.
  - FETCH at T+1 (`ram_rd` high during T+1).
  - `ioctl_din` valid at T+3.
- `hps_io` samples `ioctl_din` ≥ 8 cycles after `ioctl_rd`, giving 5 cycles of margin.
- First byte of an upload: latency = acquire wait + 3 cycles.
- `ioctl_rd` arriving in the same cycle as LATCH: it is latched as a new pending read and served next, not dropped.
- Back-to-back `ioctl_rd` one cycle apart is not legal from `hps_io`. If the address latch is overwritten, the latest address wins.
- `save_req` and `sel` rising in the same cycle: the latch stays cleared.

## Structure
- Shared package `upload_pkg`:
  - state enum `upl_state_t` (IDLE, ACQUIRE, READY, FETCH, LATCH).
  - constant `UPL_OOR_BYTE = 8'hFF`.
  - default save index `UPL_IDX_NVRAM = 8'd4`.
- No sub-module is needed. It is a single FSM plus the request latch.
- The `system` block provides the arbiter that drives `bus_gnt` (pausing the CPU) and the dual-use RAM port.

## Test plan
- Basic read: `bus_gnt` tied 1, RAM[5]=8'hA5. `save_req` pulse → `ioctl_upload_req`=1. Raise `ioctl_upload`, index 4 → req clears. `ioctl_rd` with addr 5 → `ioctl_din`=8'hA5 at T+3.
- Delayed grant: `bus_gnt` held 0 for 20 cycles, `ioctl_rd` issued at addr 0 (RAM[0]=8'h3C). → No `ram_rd` while grant is 0. `ioctl_din`=8'h3C three cycles after grant rises.
- Out of range: ADDR_W=11, addr 2048 → `ioctl_din`=8'hFF and `ram_rd` never asserts.
- Grant loss in READY: drop `bus_gnt` for 5 cycles with a read pending → state=ACQUIRE, `bus_req`=1. Read served after regrant with correct data.
- Index mismatch: `ioctl_upload`=1, index 0, reads at addr 1 → `bus_req` stays 0 and `ioctl_din` unchanged.
- End and reset: deassert `ioctl_upload` → `done` 1-cycle pulse, `bus_req`=0. Separately, `reset_n` low during FETCH → all outputs at reset values in the same cycle.
